// File: rtl/mem_seq.sv
// Byte-serial load/store sequencer for a byte-wide RAM port.
// Splits 1/2/4/8-byte requests into little-endian single-byte accesses.
module mem_seq #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_d,
    input  logic [7:0]        mem_q
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base;
    logic [1:0]        size;
    logic [63:0]       wdata;
    logic [63:0]       asm_q;
    logic [63:0]       asm_nxt;
    logic [2:0]        cnt;
    logic [2:0]        last_idx;
    logic              last;
    logic [7:0]        wbyte;

    always_comb begin
        unique case (size)
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd1;
            2'd2:    last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
    end

    assign last    = (cnt == last_idx);
    assign wbyte   = 8'(wdata >> {cnt, 3'b000});
    assign asm_nxt = asm_q | (64'(mem_q) << {cnt, 3'b000});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (req_valid) state_nxt = req_write ? WRITE : READ;
            READ,
            WRITE:      if (last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_load  = 1'b0;
        mem_addr  = '0;
        mem_d     = '0;
        unique case (state)
            IDLE:  req_ready = 1'b1;
            READ:  mem_addr  = base + ADDR_W'(cnt);
            WRITE: begin
                mem_load = 1'b1;
                mem_addr = base + ADDR_W'(cnt);
                mem_d    = wbyte;
            end
            default: rsp_valid = 1'b1;
        endcase
    end

    // Result register is separate from the assembly register so it holds
    // across stores and across acceptance of the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base      <= '0;
            size      <= '0;
            wdata     <= '0;
            cnt       <= '0;
            asm_q     <= '0;
            rsp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        base  <= req_addr;
                        size  <= req_size;
                        wdata <= req_wdata;
                        cnt   <= '0;
                        asm_q <= '0;
                    end
                end
                READ: begin
                    asm_q <= asm_nxt;
                    if (last) rsp_rdata <= asm_nxt;
                    else      cnt       <= cnt + 3'd1;
                end
                WRITE: begin
                    if (!last) cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq with a behavioural 64 KiB byte RAM.
// Expected values are hand-computed constants.
module tb_mem_seq;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic          rsp_valid;
    logic [63:0]   rsp_rdata;
    logic          mem_load;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_d;
    logic [7:0]    mem_q;

    logic [7:0]    ram [0:65535];
    int            checks   = 0;
    int            failures = 0;

    logic [63:0]   rd;
    int            lat;
    int            loads;
    logic          seen;

    always #5 clk = ~clk;

    mem_seq #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_load  (mem_load),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    assign mem_q = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_load) ram[mem_addr] = mem_d;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; inputs are scrambled right after acceptance.
    task automatic xact(input logic w, input logic [1:0] sz,
                        input logic [15:0] a, input logic [63:0] wd,
                        output logic [63:0] r, output int l,
                        output int n);
        r = '0;
        l = -1;
        n = 0;
        @(negedge clk);
        check("ready_at_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_addr  = ~a;
                req_wdata = ~wd;
                req_size  = 2'd3;
            end
            if (mem_load) n++;
            if (rsp_valid) begin
                l = k - 1;
                r = rsp_rdata;
                break;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0000] = 8'h22;
        ram[16'h0203] = 8'h3C;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_mem_load", 64'(mem_load), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_d", 64'(mem_d), 64'd0);
        reset = 1'b0;

        xact(1'b0, 2'd0, 16'h0000, 64'd0, rd, lat, loads);
        check("ld1_data", rd, 64'h22);
        check("ld1_lat", 64'(lat), 64'd1);
        check("ld1_loads", 64'(loads), 64'd0);

        xact(1'b1, 2'd3, 16'h0100, 64'h1122334455667788, rd, lat, loads);
        check("st8_lat", 64'(lat), 64'd8);
        check("st8_loads", 64'(loads), 64'd8);
        check("st8_mem", {ram[16'h107], ram[16'h106], ram[16'h105],
                          ram[16'h104], ram[16'h103], ram[16'h102],
                          ram[16'h101], ram[16'h100]},
              64'h1122334455667788);

        xact(1'b0, 2'd2, 16'h0100, 64'd0, rd, lat, loads);
        check("ld4_data", rd, 64'h55667788);
        check("ld4_lat", 64'(lat), 64'd4);

        xact(1'b0, 2'd1, 16'h0106, 64'd0, rd, lat, loads);
        check("ld2_data", rd, 64'h1122);
        check("ld2_lat", 64'(lat), 64'd2);

        xact(1'b1, 2'd2, 16'hFFFE, 64'hAABBCCDD, rd, lat, loads);
        check("st4wrap_mem", 64'({ram[16'h0001], ram[16'h0000],
                                  ram[16'hFFFF], ram[16'hFFFE]}),
              64'hAABBCCDD);
        check("st4wrap_lat", 64'(lat), 64'd4);

        xact(1'b0, 2'd1, 16'hFFFF, 64'd0, rd, lat, loads);
        check("ld2wrap_data", rd, 64'hBBCC);

        xact(1'b1, 2'd0, 16'h0400, 64'h77, rd, lat, loads);
        check("rdata_hold", rd, 64'hBBCC);
        check("st1_mem", 64'(ram[16'h0400]), 64'h77);
        check("st1_lat", 64'(lat), 64'd1);

        // Reset in the middle of an 8-byte store
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd3;
        req_addr  = 16'h0200;
        req_wdata = '1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_load_pre", 64'(mem_load), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_load_drop", 64'(mem_load), 64'd0);
        check("rst_mid_addr", 64'(mem_addr), 64'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rst_mid_no_rsp", 64'(seen), 64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        check("rst_mid_mem", 64'({ram[16'h203], ram[16'h202],
                                  ram[16'h201], ram[16'h200]}),
              64'h3CFFFFFF);

        // Back-to-back with req_valid held high
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 16'h0300;
        req_wdata = 64'h5A;
        check("b2b_ready0", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy_w", 64'(req_ready), 64'd0);
        check("b2b_load", 64'(mem_load), 64'd1);
        check("b2b_d", 64'(mem_d), 64'h5A);
        req_write = 1'b0;
        req_wdata = '0;
        @(negedge clk);
        check("b2b_rsp_w", 64'(rsp_valid), 64'd1);
        check("b2b_busy_d", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("b2b_idle", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("b2b_busy_r", 64'(req_ready), 64'd0);
        check("b2b_raddr", 64'(mem_addr), 64'h300);
        check("b2b_rload", 64'(mem_load), 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp_r", 64'(rsp_valid), 64'd1);
        check("b2b_rdata", rsp_rdata, 64'h5A);
        @(negedge clk);
        check("b2b_end_ready", 64'(req_ready), 64'd1);
        check("b2b_end_rsp", 64'(rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
